inst_mem_fetch: RTL



---
 rtl/inst_mem_pkg.sv | 39 +++
 rtl/inst_mem_fetch_bram.sv | 30 +++
 rtl/inst_mem_fetch.sv | 117 +++++++++++
 3 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the instruction-memory fetch block.
package inst_mem_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_MISALIGNED = 2'd1,
    ERR_RANGE      = 2'd2
  } fetch_err_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    fetch_err_t  err;
  } resp_entry_t;

  // Alignment first, then an unsigned 33-bit window check so the top never wraps.
  function automatic fetch_err_t classify(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int unsigned aw);
    logic [32:0] a33;
    logic [32:0] b33;
    logic [32:0] lim;
    a33 = {1'b0, addr};
    b33 = {1'b0, base};
    lim = b33 + (33'd1 << (aw + 2));
    if (addr[1:0] != 2'b00)            return ERR_MISALIGNED;
    else if (a33 < b33 || a33 >= lim) return ERR_RANGE;
    else                               return ERR_NONE;
  endfunction

endpackage

// File: rtl/inst_mem_fetch_bram.sv
// Single-port 32-bit BRAM with byte enables and 1-cycle registered read.
module bram_sp_be #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            be,
  output logic [31:0]           rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  (* ram_style = "block" *) logic [31:0] mem [DEPTH];

  // rdata only moves on a read so a stalled response can keep using it.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/inst_mem_fetch.sv
// Instruction memory with valid/ready fetch, 2-deep response skid buffer, flush and loader port.
module inst_mem_fetch
  import inst_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic [31:0] resp_addr,
  output logic [1:0]  resp_err,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be
);

  occ_state_t  occ, occ_n;
  logic        s1_valid, s1_valid_n;
  logic [31:0] s1_addr;
  fetch_err_t  s1_err;
  logic [31:0] bram_rdata;
  resp_entry_t buf_q [2];
  resp_entry_t s1_entry, head;
  fetch_err_t  req_err;
  logic        wr_ok, accept, fire, pop, push, push_hi;
  logic [1:0]  buf_cnt;
  logic [ADDR_WIDTH-1:0] req_idx, wr_idx;

  assign req_err = classify(req_addr, BASE_ADDR, ADDR_WIDTH);
  assign wr_ok   = (classify(wr_addr & ~32'h3, BASE_ADDR, ADDR_WIDTH) == ERR_NONE);
  assign req_idx = ADDR_WIDTH'((req_addr - BASE_ADDR) >> 2);
  assign wr_idx  = ADDR_WIDTH'((wr_addr - BASE_ADDR) >> 2);

  assign req_ready = !rst && !wr_en && (occ != OCC_FULL);
  assign accept    = req_valid && req_ready;
  assign fire      = resp_valid && resp_ready;

  // occ covers the returning read (s1) plus buffered entries, so the buffer count falls out.
  assign buf_cnt  = 2'(occ) - {1'b0, s1_valid};
  assign s1_entry = '{inst: (s1_err == ERR_NONE) ? bram_rdata : NOP_INST,
                      addr: s1_addr, err: s1_err};
  assign head     = (buf_cnt != 2'd0) ? buf_q[0] : s1_entry;
  assign pop      = fire && (buf_cnt != 2'd0);
  assign push     = s1_valid && !(fire && buf_cnt == 2'd0) && !flush;
  assign push_hi  = (buf_cnt == 2'd2) || (buf_cnt == 2'd1 && !pop);

  assign resp_inst = resp_valid ? head.inst : 32'd0;
  assign resp_addr = resp_valid ? head.addr : 32'd0;
  assign resp_err  = resp_valid ? head.err  : ERR_NONE;

  bram_sp_be #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_bram (
    .clk   (clk),
    .en    (accept && (req_err == ERR_NONE)),
    .we    (wr_en && wr_ok),
    .addr  (wr_en ? wr_idx : req_idx),
    .wdata (wr_data),
    .be    (wr_be),
    .rdata (bram_rdata)
  );

  // Occupancy next state; a flush keeps only a redirect accepted in the same cycle.
  always_comb begin
    occ_n      = occ;
    s1_valid_n = accept;
    if (flush) begin
      occ_n = accept ? OCC_ONE : OCC_EMPTY;
    end else begin
      case ({accept, fire})
        2'b10:   occ_n = (occ == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
        2'b01:   occ_n = (occ == OCC_FULL)  ? OCC_ONE : OCC_EMPTY;
        default: occ_n = occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ        <= OCC_EMPTY;
      s1_valid   <= 1'b0;
      s1_addr    <= 32'd0;
      s1_err     <= ERR_NONE;
      resp_valid <= 1'b0;
    end else begin
      occ        <= occ_n;
      s1_valid   <= s1_valid_n;
      resp_valid <= (occ_n != OCC_EMPTY);
      if (accept) begin
        s1_addr <= req_addr;
        s1_err  <= req_err;
      end
    end
  end

  // Skid buffer: shift on pop, returning read lands in the first free slot.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (pop) buf_q[0] <= buf_q[1];
      if (push) begin
        if (push_hi) buf_q[1] <= s1_entry;
        else         buf_q[0] <= s1_entry;
      end
    end
  end

endmodule
